// File: rtl/leitor_teclado_pkg.sv
// Shared types and key codes for the keypad reader and the setup/lock consumers.
// Also holds the keypad decode helpers used by leitor_teclado.
package leitor_teclado_pkg;

    localparam int NUM_DIGITS = 20;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef logic [3:0][3:0]            bcdPac_t;
    typedef logic [NUM_DIGITS-1:0][3:0] senhaPac_t;

    typedef struct packed {
        logic      valid;
        senhaPac_t senha;
    } setupPac_t;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        WAIT_REL  = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] onehot_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Physical layout: rows 1-2-3-A / 4-5-6-B / 7-8-9-C / *-0-#-D.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (col == 2'd3) begin
            code = 4'hA + {2'b00, row};
        end else if (row != 2'd3) begin
            code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
        end else begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'h0;
                default: code = KEY_HASH;
            endcase
        end
        return code;
    endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for asynchronous inputs, one independent chain per bit.
module sincronizador #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= d[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign q[gi] = sync_reg;
        end
    endgenerate

endmodule

// File: rtl/leitor_teclado.sv
// 4x4 keypad scanner with press/release debounce and a 20-digit entry buffer;
// '#' emits the buffer as a one-cycle packet, '*' clears it.
module leitor_teclado
    import leitor_teclado_pkg::*;
#(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] lin,
    output logic [3:0] col,
    output senhaPac_t  digitos_value,
    output logic       digitos_valid
);

    localparam int SCW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_CYCLES - 1);
    localparam logic [DBW-1:0] DEB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam senhaPac_t      ALL_F     = '1;
    localparam logic [4:0]     MAX_COUNT = 5'(NUM_DIGITS);

    logic [3:0]     lin_s;
    state_t         state_reg, state_next;
    logic [SCW-1:0] scan_cnt_reg;
    logic [DBW-1:0] deb_cnt_reg;
    logic [3:0]     col_reg;
    logic [3:0]     lin_cap_reg;
    senhaPac_t      digits_reg;
    logic [4:0]     count_reg;
    senhaPac_t      digitos_value_reg;
    logic           digitos_valid_reg;

    logic       lin_match;
    logic       press_done;
    logic       rel_done;
    logic       key_ok;
    logic [3:0] key;
    logic       push_digit;
    logic       clear_buf;
    logic       emit;

    sincronizador #(.WIDTH(4)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (lin),
        .q   (lin_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= SCAN;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SCAN:      if (lin_s != 4'd0) state_next = DEB_PRESS;
            DEB_PRESS: if (!lin_match) state_next = SCAN;
                       else if (deb_cnt_reg == DEB_LAST) state_next = WAIT_REL;
            WAIT_REL:  if (lin_s == 4'd0) state_next = DEB_REL;
            DEB_REL:   if (lin_s != 4'd0) state_next = WAIT_REL;
                       else if (deb_cnt_reg == DEB_LAST) state_next = SCAN;
            default:   state_next = SCAN;
        endcase
    end

    // Decode uses the frozen column and the captured row pattern.
    always_comb begin
        lin_match  = (lin_s == lin_cap_reg);
        press_done = (state_reg == DEB_PRESS) && lin_match && (deb_cnt_reg == DEB_LAST);
        rel_done   = (state_reg == DEB_REL) && (lin_s == 4'd0) && (deb_cnt_reg == DEB_LAST);
        key_ok     = is_onehot(lin_cap_reg);
        key        = key_code(onehot_index(lin_cap_reg), onehot_index(col_reg));
        push_digit = press_done && key_ok && (key <= 4'd9);
        clear_buf  = press_done && key_ok && (key == KEY_STAR);
        emit       = press_done && key_ok && (key == KEY_HASH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt_reg <= '0;
            deb_cnt_reg  <= '0;
            col_reg      <= 4'b0001;
            lin_cap_reg  <= 4'd0;
        end else begin
            if (state_next != state_reg)
                deb_cnt_reg <= '0;
            else if (state_reg == DEB_PRESS || state_reg == DEB_REL)
                deb_cnt_reg <= deb_cnt_reg + DBW'(1);

            case (state_reg)
                SCAN: begin
                    if (lin_s != 4'd0) begin
                        lin_cap_reg  <= lin_s;
                        scan_cnt_reg <= '0;
                    end else if (scan_cnt_reg == SCAN_LAST) begin
                        scan_cnt_reg <= '0;
                        col_reg      <= {col_reg[2:0], col_reg[3]};
                    end else begin
                        scan_cnt_reg <= scan_cnt_reg + SCW'(1);
                    end
                end
                DEB_REL: begin
                    if (rel_done) begin
                        scan_cnt_reg <= '0;
                        col_reg      <= {col_reg[2:0], col_reg[3]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Newest digit lands in digits[0]; a full buffer silently drops further digits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digits_reg        <= ALL_F;
            count_reg         <= 5'd0;
            digitos_value_reg <= ALL_F;
            digitos_valid_reg <= 1'b0;
        end else begin
            digitos_valid_reg <= emit;
            if (push_digit) begin
                if (count_reg < MAX_COUNT) begin
                    digits_reg <= {digits_reg[NUM_DIGITS-2:0], key};
                    count_reg  <= count_reg + 5'd1;
                end
            end else if (clear_buf) begin
                digits_reg <= ALL_F;
                count_reg  <= 5'd0;
            end else if (emit) begin
                digitos_value_reg <= digits_reg;
                digits_reg        <= ALL_F;
                count_reg         <= 5'd0;
            end
        end
    end

    assign col           = col_reg;
    assign digitos_value = digitos_value_reg;
    assign digitos_valid = digitos_valid_reg;

endmodule

// File: tb/tb_leitor_teclado.sv
// Directed bench for leitor_teclado: a behavioural keypad drives lin from col,
// a negedge monitor records packets, and one initial block checks results.
module tb_leitor_teclado;
    import leitor_teclado_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] lin;
    logic [3:0] col;
    senhaPac_t  digitos_value;
    logic       digitos_valid;

    always #5 clk = ~clk;

    leitor_teclado #(
        .SCAN_CYCLES     (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .lin           (lin),
        .col           (col),
        .digitos_value (digitos_value),
        .digitos_valid (digitos_valid)
    );

    logic       key_down   = 1'b0;
    logic [3:0] key_rows   = 4'd0;
    int         key_col    = 0;
    logic       glitch_on  = 1'b0;
    logic [3:0] glitch_val = 4'd0;

    // Pressed switch connects its column line to its row line(s).
    always_comb begin
        lin = 4'd0;
        if (glitch_on)
            lin = glitch_val;
        else if (key_down && col[key_col])
            lin = key_rows;
    end

    int        pulses      = 0;
    int        long_pulses = 0;
    senhaPac_t last_pkt    = '1;
    logic      prev_valid  = 1'b0;

    always @(negedge clk) begin
        if (digitos_valid) begin
            pulses++;
            last_pkt = digitos_value;
            if (prev_valid) long_pulses++;
        end
        prev_valid = digitos_valid;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic key_pos(input logic [3:0] code, output logic [3:0] rows, output int c);
        int r;
        case (code)
            4'h1: begin r = 0; c = 0; end
            4'h2: begin r = 0; c = 1; end
            4'h3: begin r = 0; c = 2; end
            4'hA: begin r = 0; c = 3; end
            4'h4: begin r = 1; c = 0; end
            4'h5: begin r = 1; c = 1; end
            4'h6: begin r = 1; c = 2; end
            4'hB: begin r = 1; c = 3; end
            4'h7: begin r = 2; c = 0; end
            4'h8: begin r = 2; c = 1; end
            4'h9: begin r = 2; c = 2; end
            4'hC: begin r = 2; c = 3; end
            4'hE: begin r = 3; c = 0; end
            4'h0: begin r = 3; c = 1; end
            4'hF: begin r = 3; c = 2; end
            default: begin r = 3; c = 3; end
        endcase
        rows = 4'd1 << r;
    endtask

    task automatic press(input logic [3:0] code, input int hold);
        logic [3:0] rows;
        int         c;
        key_pos(code, rows, c);
        key_rows = rows;
        key_col  = c;
        key_down = 1'b1;
        repeat (hold) @(negedge clk);
        key_down = 1'b0;
        repeat (24) @(negedge clk);
    endtask

    logic found;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_col", 80'(col), 80'(4'b0001));
        check("rst_valid", 80'(digitos_valid), 80'(1'b0));
        check("rst_value", digitos_value, {80{1'b1}});
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 1,2,3,4,#
        press(4'h1, 40); press(4'h2, 40); press(4'h3, 40); press(4'h4, 40);
        check("c1_count", 80'(dut.count_reg), 80'(5'd4));
        press(4'hF, 40);
        check("c1_pulses", 80'(pulses), 80'(1));
        check("c1_pkt", last_pkt, 80'hFFFF_FFFF_FFFF_FFFF_1234);
        repeat (50) @(negedge clk);
        check("c1_hold", digitos_value, 80'hFFFF_FFFF_FFFF_FFFF_1234);

        // 5,5,*,7,#
        press(4'h5, 40); press(4'h5, 40); press(4'hE, 40);
        check("c2_star_nopkt", 80'(pulses), 80'(1));
        check("c2_star_clr", 80'(dut.count_reg), 80'(5'd0));
        press(4'h7, 40); press(4'hF, 40);
        check("c2_pulses", 80'(pulses), 80'(2));
        check("c2_pkt", last_pkt, 80'hFFFF_FFFF_FFFF_FFFF_FFF7);

        // Short glitch on row 1
        glitch_val = 4'b0010;
        glitch_on  = 1'b1;
        repeat (3) @(negedge clk);
        glitch_on  = 1'b0;
        repeat (20) @(negedge clk);
        check("gl_state", 80'(dut.state_reg), 80'(SCAN));
        check("gl_count", 80'(dut.count_reg), 80'(5'd0));
        check("gl_pulses", 80'(pulses), 80'(2));
        press(4'hF, 40);
        check("gl_empty_pulses", 80'(pulses), 80'(3));
        check("gl_empty_pkt", last_pkt, {80{1'b1}});

        // 22 x 9 then #
        for (int i = 0; i < 22; i++) press(4'h9, 40);
        check("c3_sat", 80'(dut.count_reg), 80'(5'd20));
        press(4'hF, 40);
        check("c3_pulses", 80'(pulses), 80'(4));
        check("c3_pkt", last_pkt, 80'h9999_9999_9999_9999_9999);

        // Rows 0+1 together, then A, then #
        press(4'h6, 40);
        key_rows = 4'b0011;
        key_col  = 0;
        key_down = 1'b1;
        repeat (40) @(negedge clk);
        key_down = 1'b0;
        repeat (24) @(negedge clk);
        check("c4_multi", 80'(dut.count_reg), 80'(5'd1));
        press(4'hA, 40);
        check("c4_a", 80'(dut.count_reg), 80'(5'd1));
        press(4'hE, 40);
        press(4'hF, 40);
        check("c4_pulses", 80'(pulses), 80'(5));
        check("c4_pkt", last_pkt, {80{1'b1}});

        // 8 held 1000 cycles, then #
        press(4'h8, 1000);
        check("c5_single", 80'(dut.count_reg), 80'(5'd1));
        press(4'hF, 40);
        check("c5_pulses", 80'(pulses), 80'(6));
        check("c5_pkt", last_pkt, 80'hFFFF_FFFF_FFFF_FFFF_FFF8);

        // 3 then # interrupted by reset during its debounce
        press(4'h3, 40);
        begin
            logic [3:0] rows;
            int         c;
            key_pos(4'hF, rows, c);
            key_rows = rows;
            key_col  = c;
        end
        key_down = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (dut.state_reg == DEB_PRESS) found = 1'b1;
        end
        check("c6_deb_reached", 80'(found), 80'(1'b1));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        key_down = 1'b0;
        repeat (4) @(negedge clk);
        check("c6_rst_col", 80'(col), 80'(4'b0001));
        rst = 1'b1;
        repeat (60) @(negedge clk);
        check("c6_pulses", 80'(pulses), 80'(6));
        check("c6_valid", 80'(digitos_valid), 80'(1'b0));
        check("c6_value", digitos_value, {80{1'b1}});
        check("c6_count", 80'(dut.count_reg), 80'(5'd0));
        check("pulse_width", 80'(long_pulses), 80'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/leitor_teclado.md
LEITOR_TECLADO -- requirements
Module: leitor_teclado

Interface
REQ-001 SHALL have parameter SCAN_CYCLES, default 4: clock cycles each column stays driven while scanning.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 8: consecutive stable cycles required for press or release.
REQ-003 SHALL have port clk  input  1  single system clock; all flops on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port lin  input  4  keypad row sense, active-high; lin[r] is row r.
REQ-006 SHALL have port col  output  4  keypad column drive, one-hot active-high; col[c] is column c.
REQ-007 SHALL have port digitos_value  output  senhaPac_t (20 x 4 bit)  assembled digit packet for the setup and lock consumers.
REQ-008 SHALL have port digitos_valid  output  1  one-cycle pulse; digitos_value is valid that cycle.

Function
REQ-009 SHALL pass lin through a 2-flop synchronizer before any use; all lin references below mean the synchronized value.
REQ-010 Key map (row, col) SHALL be: r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = *,0,#,D. Codes: digits 0x0-0x9, A-D 0xA-0xD, * 0xE, # 0xF.
REQ-011 FSM states SHALL be SCAN, DEB_PRESS, WAIT_REL, DEB_REL.
REQ-012 SCAN: col SHALL rotate 0001->0010->0100->1000->0001, advancing every SCAN_CYCLES cycles; when lin != 0, freeze col, capture lin, go to DEB_PRESS.
REQ-013 DEB_PRESS: count while lin equals the captured value; any change returns to SCAN with counter cleared; when the count reaches DEBOUNCE_CYCLES, decode the key and go to WAIT_REL.
REQ-014 A press with more than one lin bit set SHALL be discarded (no action) and still go to WAIT_REL.
REQ-015 WAIT_REL: col held; on lin == 0 go to DEB_REL.
REQ-016 DEB_REL: count while lin == 0; any nonzero lin returns to WAIT_REL; at DEBOUNCE_CYCLES go to SCAN and resume rotation from the next column.
REQ-017 Internal buffer: 20 nibbles plus a 5-bit count 0..20; empty buffer is all 0xF.
REQ-018 Digit key 0-9: if count < 20, shift digits[i] <= digits[i-1] for i = 19..1, load digits[0] <= key, and count++; if count == 20, discard the digit.
REQ-019 * key SHALL clear the buffer to all 0xF and count to 0, with no packet emitted.
REQ-020 # key SHALL copy the buffer to digitos_value, pulse digitos_valid for exactly 1 cycle (the cycle after debounce completes), and clear the buffer in the same cycle.
REQ-021 # on an empty buffer SHALL still emit an all-0xF packet.
REQ-022 Keys A-D SHALL be ignored.
REQ-023 digitos_value SHALL hold its value between packets.
REQ-024 A held key SHALL produce exactly one action (no auto-repeat).

Reset
REQ-025 On rst low, asynchronously: state = SCAN, col = 0001, scan and debounce counters = 0, buffer = all 0xF, count = 0, digitos_value = all 0xF, digitos_valid = 0, synchronizer flops = 0.
REQ-026 Reset asserted mid-debounce or mid-entry SHALL discard all partial input; no packet is emitted.

Structure
REQ-027 bcdPac_t, senhaPac_t, setupPac_t and the key-code constants (KEY_STAR = 0xE, KEY_HASH = 0xF) SHALL reside in a shared package used by setup and leitor_teclado.
REQ-028 The 2-flop synchronizer SHALL be a sub-module named sincronizador, 4 bits wide.
REQ-029 The FSM, counters and buffer SHALL live in leitor_teclado.

Verification
REQ-030 Bench SHALL cover: press 1,2,3,4 then # (each held > DEBOUNCE_CYCLES+4) -> one digitos_valid pulse, digits[3:0] = 1,2,3,4 with digits[0] = 4, digits[19:4] = 0xF.
REQ-031 Bench SHALL cover: 5,5,*,7,# -> packet digits[0] = 7, all other digits 0xF; no packet on *.
REQ-032 Bench SHALL cover: lin glitch shorter than DEBOUNCE_CYCLES on row 1 -> no buffer change, FSM back in SCAN.
REQ-033 Bench SHALL cover: 22 presses of 9 then # -> all 20 digits = 9, count saturated at 20.
REQ-034 Bench SHALL cover: rows 0 and 1 pressed together, then A, then # -> press discarded, A ignored, all-0xF packet emitted.
REQ-035 Bench SHALL cover: 8 held 1000 cycles, then #; and rst pulsed after 3,# debounce -> first case emits a single 8 only; second case gives digitos_valid = 0 and digitos_value = all 0xF.
